exe_stage_ctrl: RTL

// Sequences the pipelined Y86-64 execute stage. Owns the E pipeline register (stall/bubble),
// the condition-code register and CC-update gating, and ALU operand/function selection.

---
 rtl/y86_pkg.sv | 56 +++++
 rtl/exe_stage_ctrl_if.sv | 51 +++++
 rtl/exe_cond_eval.sv | 34 +++
 rtl/exe_stage_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute-stage controller: icodes, status codes,
// condition-code layout, jump/cmov conditions and controller state encodings.
package y86_pkg;

   localparam logic [3:0] I_HALT  = 4'h0;
   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_RRMOV = 4'h2;   // rrmovq and cmovXX share this icode
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;

   localparam logic [2:0] S_BUB = 3'd0;
   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_HLT = 3'd2;
   localparam logic [2:0] S_ADR = 3'd3;
   localparam logic [2:0] S_INS = 3'd4;

   localparam logic [3:0] RNONE = 4'hF;

   localparam int unsigned CC_ZF = 0;
   localparam int unsigned CC_SF = 1;
   localparam int unsigned CC_OF = 2;

   localparam logic [3:0] C_ALWAYS = 4'h0;
   localparam logic [3:0] C_LE     = 4'h1;
   localparam logic [3:0] C_L      = 4'h2;
   localparam logic [3:0] C_E      = 4'h3;
   localparam logic [3:0] C_NE     = 4'h4;
   localparam logic [3:0] C_GE     = 4'h5;
   localparam logic [3:0] C_G      = 4'h6;

   typedef enum logic [1:0] {
      CTL_RUN  = 2'b00,
      CTL_MASK = 2'b01,
      CTL_HALT = 2'b10
   } ctl_state_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_XOR = 2'b11
   } alu_fun_e;

   // A status that stops architectural state updates downstream of it.
   function automatic logic is_exc(input logic [2:0] s);
      return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
   endfunction

endpackage

// File: rtl/exe_stage_ctrl_if.sv
// Decode-to-execute bus: decode fields and pipeline status in, E register contents,
// ALU controls, condition codes and controller state out.
interface exe_stage_ctrl_if #(
   parameter int unsigned W = 64
);

   logic         E_stall;
   logic         E_bubble;
   logic [2:0]   d_stat;
   logic [3:0]   d_icode;
   logic [3:0]   d_ifun;
   logic [W-1:0] d_valC;
   logic [W-1:0] d_valA;
   logic [W-1:0] d_valB;
   logic [3:0]   d_dstE;
   logic [3:0]   d_dstM;
   logic [2:0]   alu_cf;
   logic [2:0]   m_stat;
   logic [2:0]   W_stat;

   logic [2:0]   E_stat;
   logic [3:0]   E_icode;
   logic [3:0]   E_ifun;
   logic [W-1:0] E_valC;
   logic [W-1:0] E_valA;
   logic [W-1:0] E_valB;
   logic [3:0]   E_dstE;
   logic [3:0]   E_dstM;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [1:0]   alu_fun;
   logic [2:0]   cc;
   logic         e_cnd;
   logic [3:0]   e_dstE;
   logic [1:0]   ctl_state;

   modport master (
      output E_stall, E_bubble, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
             d_dstE, d_dstM, alu_cf, m_stat, W_stat,
      input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
             alu_a, alu_b, alu_fun, cc, e_cnd, e_dstE, ctl_state
   );

   modport slave (
      input  E_stall, E_bubble, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
             d_dstE, d_dstM, alu_cf, m_stat, W_stat,
      output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
             alu_a, alu_b, alu_fun, cc, e_cnd, e_dstE, ctl_state
   );

endinterface

// File: rtl/exe_cond_eval.sv
// Evaluates a jXX/cmovXX condition (ifun) against the condition codes {OF,SF,ZF}.
module exe_cond_eval
   import y86_pkg::*;
(
   input  logic [3:0] ifun,
   input  logic [2:0] cc,
   output logic       cnd
);

   logic zf;
   logic sf;
   logic ovf;
   logic lt;

   assign zf  = cc[CC_ZF];
   assign sf  = cc[CC_SF];
   assign ovf = cc[CC_OF];
   assign lt  = sf ^ ovf;

   always_comb begin
      cnd = 1'b0;
      case (ifun)
         C_ALWAYS: cnd = 1'b1;
         C_LE:     cnd = lt | zf;
         C_L:      cnd = lt;
         C_E:      cnd = zf;
         C_NE:     cnd = ~zf;
         C_GE:     cnd = ~lt;
         C_G:      cnd = ~lt & ~zf;
         default:  cnd = 1'b0;
      endcase
   end

endmodule

// File: rtl/exe_stage_ctrl.sv
// Y86-64 execute-stage controller: E pipeline register, condition codes with
// exception-aware update gating, ALU operand/function selection and cmov squash.
module exe_stage_ctrl
   import y86_pkg::*;
#(
   parameter int unsigned W      = 64,
   parameter logic [2:0]  CC_RST = 3'b001
) (
   input  logic           clk,
   input  logic           reset,
   exe_stage_ctrl_if.slave bus
);

   typedef struct packed {
      logic [2:0]   stat;
      logic [3:0]   icode;
      logic [3:0]   ifun;
      logic [W-1:0] valc;
      logic [W-1:0] vala;
      logic [W-1:0] valb;
      logic [3:0]   dste;
      logic [3:0]   dstm;
   } ereg_t;

   localparam ereg_t E_BUBBLE = '{
      stat:  S_BUB,
      icode: I_NOP,
      ifun:  4'h0,
      valc:  '0,
      vala:  '0,
      valb:  '0,
      dste:  RNONE,
      dstm:  RNONE
   };

   localparam logic [W-1:0] STACK_DEC = {{(W-4){1'b1}}, 4'b1000};
   localparam logic [W-1:0] STACK_INC = {{(W-4){1'b0}}, 4'b1000};

   ereg_t      ereg_q;
   ereg_t      ereg_d;
   ctl_state_e state_q;
   ctl_state_e state_d;
   logic [2:0] cc_q;
   logic [2:0] cc_d;

   logic         m_exc;
   logic         w_exc;
   logic         set_cc;
   logic         cnd;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   alu_fun_e     alu_fun;

   assign m_exc = is_exc(bus.m_stat);
   assign w_exc = is_exc(bus.W_stat);

   always_ff @(posedge clk) begin
      // NOTE: every state flop uses <= so all of them sample pre-edge values together.
      if (reset) begin
         ereg_q  <= E_BUBBLE;
         cc_q    <= CC_RST;
         state_q <= CTL_RUN;
      end else begin
         ereg_q  <= ereg_d;
         cc_q    <= cc_d;
         state_q <= state_d;
      end
   end

   always_comb begin : e_reg_next
      ereg_d = ereg_q;
      if (state_q != CTL_HALT) begin
         // Bubble beats stall when both are asserted.
         if (bus.E_bubble) begin
            ereg_d = E_BUBBLE;
         end else if (!bus.E_stall) begin
            ereg_d = '{
               stat:  bus.d_stat,
               icode: bus.d_icode,
               ifun:  bus.d_ifun,
               valc:  bus.d_valC,
               vala:  bus.d_valA,
               valb:  bus.d_valB,
               dste:  bus.d_dstE,
               dstm:  bus.d_dstM
            };
         end
      end
   end

   always_comb begin : ctl_fsm_next
      state_d = state_q;
      case (state_q)
         CTL_RUN: begin
            if (w_exc)      state_d = CTL_HALT;
            else if (m_exc) state_d = CTL_MASK;
         end
         CTL_MASK: begin
            if (w_exc)       state_d = CTL_HALT;
            else if (!m_exc) state_d = CTL_RUN;
         end
         CTL_HALT: state_d = CTL_HALT;
         default:  state_d = CTL_RUN;
      endcase
   end

   // Same-cycle exceptions further down the pipe must block the CC write.
   always_comb begin : cc_next
      set_cc = (ereg_q.icode == I_OPQ) && (ereg_q.stat == S_AOK) &&
               (state_q == CTL_RUN) && !m_exc && !w_exc;
      cc_d   = set_cc ? bus.alu_cf : cc_q;
   end

   always_comb begin : alu_ctrl
      alu_a   = '0;
      alu_b   = '0;
      alu_fun = ALU_ADD;
      case (ereg_q.icode)
         I_RRMOV, I_OPQ:            alu_a = ereg_q.vala;
         I_IRMOV, I_RMMOV, I_MRMOV: alu_a = ereg_q.valc;
         I_CALL, I_PUSH:            alu_a = STACK_DEC;
         I_RET, I_POP:              alu_a = STACK_INC;
         default:                   alu_a = '0;
      endcase
      case (ereg_q.icode)
         I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = ereg_q.valb;
         default:                                                alu_b = '0;
      endcase
      if (ereg_q.icode == I_OPQ) begin
         alu_fun = alu_fun_e'(ereg_q.ifun[1:0]);
      end
   end

   exe_cond_eval u_cond (
      .ifun (ereg_q.ifun),
      .cc   (cc_q),
      .cnd  (cnd)
   );

   assign bus.E_stat    = ereg_q.stat;
   assign bus.E_icode   = ereg_q.icode;
   assign bus.E_ifun    = ereg_q.ifun;
   assign bus.E_valC    = ereg_q.valc;
   assign bus.E_valA    = ereg_q.vala;
   assign bus.E_valB    = ereg_q.valb;
   assign bus.E_dstE    = ereg_q.dste;
   assign bus.E_dstM    = ereg_q.dstm;
   assign bus.alu_a     = alu_a;
   assign bus.alu_b     = alu_b;
   assign bus.alu_fun   = alu_fun;
   assign bus.cc        = cc_q;
   assign bus.e_cnd     = cnd;
   assign bus.e_dstE    = ((ereg_q.icode == I_RRMOV) && !cnd) ? RNONE : ereg_q.dste;
   assign bus.ctl_state = state_q;

endmodule
